// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence detector.
package seq_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SEQ_PATTERN_DEF = 8'b0001_0111;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with match counter and a lock FSM that tracks
// matches recurring with period exactly PAT_LEN.
module seq_detector
    import seq_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 8,
    parameter logic [PAT_LEN-1:0]   PATTERN = SEQ_PATTERN_DEF,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          LOCK_N  = 3,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             lock,
    output logic             lost
);

    localparam int unsigned FW = $clog2(PAT_LEN + 1);
    localparam int unsigned SW = $clog2(LOCK_N + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
    localparam logic [FW-1:0] LEN_M1   = FW'(PAT_LEN - 1);
    localparam logic [SW-1:0] STREAK_LOCK = SW'(LOCK_N);

    logic [PAT_LEN-2:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic [FW-1:0]      r_gap;
    logic [SW-1:0]      r_streak;
    state_t             r_state;
    logic               r_match;
    logic               r_lock;
    logic               r_lost;

    logic [PAT_LEN-1:0] w_window;
    logic               w_match;
    logic               w_gap_full;
    logic               w_periodic;
    logic               w_miss;

    assign w_window   = {r_hist, din};
    assign w_match    = din_valid && (r_fill >= LEN_M1) && (w_window == PATTERN);
    assign w_gap_full = (r_gap == LEN_M1);
    assign w_periodic = w_match && w_gap_full;
    assign w_miss     = din_valid && w_gap_full && !w_match;

    // gap saturates at PAT_LEN so a long silence reports a single miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_gap    <= '0;
            r_streak <= '0;
            r_state  <= SEARCH;
            r_match  <= 1'b0;
            r_lock   <= 1'b0;
            r_lost   <= 1'b0;
        end else if (clear) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_gap    <= '0;
            r_streak <= '0;
            r_state  <= SEARCH;
            r_match  <= 1'b0;
            r_lock   <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_match <= w_match;
            r_lost  <= 1'b0;
            if (din_valid) begin
                r_hist <= w_window[PAT_LEN-2:0];

                if (w_match && !OVERLAP) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + 1'b1;
                end

                if (w_match) begin
                    r_gap <= '0;
                end else if (r_gap != FILL_MAX) begin
                    r_gap <= r_gap + 1'b1;
                end

                case (r_state)
                    SEARCH: begin
                        if (w_match) begin
                            r_state  <= TRACK;
                            r_streak <= SW'(1);
                        end
                    end
                    TRACK: begin
                        if (w_periodic) begin
                            r_streak <= r_streak + 1'b1;
                            if (r_streak + 1'b1 == STREAK_LOCK) begin
                                r_state <= LOCKED;
                                r_lock  <= 1'b1;
                            end
                        end else if (w_match) begin
                            r_streak <= SW'(1);
                        end else if (w_miss) begin
                            r_state  <= SEARCH;
                            r_streak <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_periodic) begin
                            r_state <= LOCKED;
                        end else if (w_match) begin
                            r_state  <= TRACK;
                            r_streak <= SW'(1);
                            r_lock   <= 1'b0;
                            r_lost   <= 1'b1;
                        end else if (w_miss) begin
                            r_state  <= SEARCH;
                            r_streak <= '0;
                            r_lock   <= 1'b0;
                            r_lost   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_streak <= '0;
                        r_lock   <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (w_match),
        .q     (match_cnt)
    );

    assign match = r_match;
    assign lock  = r_lock;
    assign lost  = r_lost;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: default, overlap pair and narrow-counter instances.
module tb_seq_detector;

    localparam logic [7:0] PAT = 8'b0001_0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic din_a, val_a, clr_a, m_a, lk_a, ls_a;
    logic [7:0] cnt_a;
    logic din_b, val_b, clr_b, m_b1, lk_b1, ls_b1, m_b0, lk_b0, ls_b0;
    logic [7:0] cnt_b1, cnt_b0;
    logic din_c, val_c, clr_c, m_c, lk_c, ls_c;
    logic [1:0] cnt_c;

    int total = 0;
    int bad   = 0;
    logic [10:0] sb[$];
    logic [10:0] exp_v;

    seq_detector dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clr_a), .din(din_a), .din_valid(val_a),
        .match(m_a), .match_cnt(cnt_a), .lock(lk_a), .lost(ls_a)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) dut_ov1 (
        .clk(clk), .rst_n(rst_n), .clear(clr_b), .din(din_b), .din_valid(val_b),
        .match(m_b1), .match_cnt(cnt_b1), .lock(lk_b1), .lost(ls_b1)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) dut_ov0 (
        .clk(clk), .rst_n(rst_n), .clear(clr_b), .din(din_b), .din_valid(val_b),
        .match(m_b0), .match_cnt(cnt_b0), .lock(lk_b0), .lost(ls_b0)
    );

    seq_detector #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clr_c), .din(din_c), .din_valid(val_c),
        .match(m_c), .match_cnt(cnt_c), .lock(lk_c), .lost(ls_c)
    );

    function automatic logic [10:0] ev(input logic m, input int c, input logic lk, input logic ls);
        logic [7:0] c8;
        c8 = c[7:0];
        return {m, c8, lk, ls};
    endfunction

    task automatic drive_a(input logic d, input logic v, input logic c);
        @(negedge clk);
        din_a = d; val_a = v; clr_a = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic d, input logic v);
        @(negedge clk);
        din_b = d; val_b = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c(input logic d, input logic v, input logic c);
        @(negedge clk);
        din_c = d; val_c = v; clr_c = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din_a = i[0]; val_a = 1'b1;
            din_b = i[0]; val_b = 1'b1;
            din_c = i[0]; val_c = 1'b1;
            sb.push_back(ev(0, 0, 0, 0));
            sb.push_back(ev(0, 0, 0, 0));
            sb.push_back(ev(0, 0, 0, 0));
            sb.push_back(ev(0, 0, 0, 0));
            @(posedge clk);
            #1;
            exp_v = sb.pop_front(); total++;
            if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                bad++; $display("FAIL reset_a cyc %0d got {match,cnt,lock,lost}=%b want %b", i, {m_a, cnt_a, lk_a, ls_a}, exp_v);
            end
            exp_v = sb.pop_front(); total++;
            if ({m_b1, cnt_b1, lk_b1, ls_b1} !== exp_v) begin
                bad++; $display("FAIL reset_ov1 cyc %0d got %b want %b", i, {m_b1, cnt_b1, lk_b1, ls_b1}, exp_v);
            end
            exp_v = sb.pop_front(); total++;
            if ({m_b0, cnt_b0, lk_b0, ls_b0} !== exp_v) begin
                bad++; $display("FAIL reset_ov0 cyc %0d got %b want %b", i, {m_b0, cnt_b0, lk_b0, ls_b0}, exp_v);
            end
            exp_v = sb.pop_front(); total++;
            if ({m_c, 6'b0, cnt_c, lk_c, ls_c} !== exp_v) begin
                bad++; $display("FAIL reset_c cyc %0d got %b want %b", i, {m_c, 6'b0, cnt_c, lk_c, ls_c}, exp_v);
            end
        end
        @(negedge clk);
        val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_match();
        for (int b = 0; b < 8; b++) begin
            sb.push_back(ev(b == 7, (b == 7) ? 1 : 0, 0, 0));
            drive_a(PAT[7-b], 1'b1, 1'b0);
            exp_v = sb.pop_front(); total++;
            if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                bad++; $display("FAIL single bit %0d got {match,cnt,lock,lost}=%b want %b", b + 1, {m_a, cnt_a, lk_a, ls_a}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ecnt = 1;
        int idx;
        for (int p = 2; p <= 4; p++) begin
            for (int b = 0; b < 8; b++) begin
                idx = (p - 1) * 8 + b + 1;
                if (p == 4 && b == 4) begin
                    for (int k = 0; k < 2; k++) begin
                        sb.push_back(ev(0, ecnt, 1, 0));
                        drive_a(1'($urandom_range(1)), 1'b0, 1'b0);
                        exp_v = sb.pop_front(); total++;
                        if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                            bad++; $display("FAIL idle_in_lock %0d got %b want %b", k, {m_a, cnt_a, lk_a, ls_a}, exp_v);
                        end
                    end
                end
                if (b == 7) ecnt++;
                sb.push_back(ev(b == 7, ecnt, idx >= 24, 0));
                drive_a(PAT[7-b], 1'b1, 1'b0);
                exp_v = sb.pop_front(); total++;
                if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                    bad++; $display("FAIL b2b bit %0d got {match,cnt,lock,lost}=%b want %b", idx, {m_a, cnt_a, lk_a, ls_a}, exp_v);
                end
            end
        end
    endtask

    task automatic test_lost();
        logic bt;
        for (int b = 0; b < 8; b++) begin
            bt = PAT[7-b] ^ (b == 2);
            sb.push_back(ev(0, 4, b != 7, b == 7));
            drive_a(bt, 1'b1, 1'b0);
            exp_v = sb.pop_front(); total++;
            if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                bad++; $display("FAIL lost bit %0d got {match,cnt,lock,lost}=%b want %b", 33 + b, {m_a, cnt_a, lk_a, ls_a}, exp_v);
            end
        end
        sb.push_back(ev(0, 4, 0, 0));
        drive_a(1'b0, 1'b0, 1'b0);
        exp_v = sb.pop_front(); total++;
        if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
            bad++; $display("FAIL lost_width got %b want %b", {m_a, cnt_a, lk_a, ls_a}, exp_v);
        end
    endtask

    task automatic test_overlap();
        logic [5:0] s;
        s = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ev(i == 3 || i == 5, (i >= 5) ? 2 : ((i >= 3) ? 1 : 0), 0, 0));
            sb.push_back(ev(i == 3, (i >= 3) ? 1 : 0, 0, 0));
            drive_b(s[5-i], 1'b1);
            exp_v = sb.pop_front(); total++;
            if ({m_b1, cnt_b1, lk_b1, ls_b1} !== exp_v) begin
                bad++; $display("FAIL overlap1 bit %0d got {match,cnt,lock,lost}=%b want %b", i + 1, {m_b1, cnt_b1, lk_b1, ls_b1}, exp_v);
            end
            exp_v = sb.pop_front(); total++;
            if ({m_b0, cnt_b0, lk_b0, ls_b0} !== exp_v) begin
                bad++; $display("FAIL overlap0 bit %0d got {match,cnt,lock,lost}=%b want %b", i + 1, {m_b0, cnt_b0, lk_b0, ls_b0}, exp_v);
            end
        end
        @(negedge clk);
        val_b = 1'b0;
    endtask

    task automatic test_saturate_clear();
        int mcount = 0;
        for (int p = 1; p <= 5; p++) begin
            for (int b = 0; b < 8; b++) begin
                if (b == 7) mcount++;
                sb.push_back(ev(b == 7, (mcount > 3) ? 3 : mcount, mcount >= 3, 0));
                drive_c(PAT[7-b], 1'b1, 1'b0);
                exp_v = sb.pop_front(); total++;
                if ({m_c, 6'b0, cnt_c, lk_c, ls_c} !== exp_v) begin
                    bad++; $display("FAIL sat p%0d bit %0d got {match,cnt,lock,lost}=%b want %b", p, b + 1, {m_c, 6'b0, cnt_c, lk_c, ls_c}, exp_v);
                end
            end
        end
        for (int b = 0; b < 8; b++) begin
            sb.push_back((b == 7) ? ev(0, 0, 0, 0) : ev(0, 3, 1, 0));
            drive_c(PAT[7-b], 1'b1, b == 7);
            exp_v = sb.pop_front(); total++;
            if ({m_c, 6'b0, cnt_c, lk_c, ls_c} !== exp_v) begin
                bad++; $display("FAIL clear bit %0d got {match,cnt,lock,lost}=%b want %b", b + 1, {m_c, 6'b0, cnt_c, lk_c, ls_c}, exp_v);
            end
        end
        sb.push_back(ev(0, 0, 0, 0));
        drive_c(1'b1, 1'b1, 1'b0);
        exp_v = sb.pop_front(); total++;
        if ({m_c, 6'b0, cnt_c, lk_c, ls_c} !== exp_v) begin
            bad++; $display("FAIL after_clear got %b want %b", {m_c, 6'b0, cnt_c, lk_c, ls_c}, exp_v);
        end
        @(negedge clk);
        val_c = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int b = 0; b < 6; b++) begin
            sb.push_back(ev(0, 4, 0, 0));
            drive_a(PAT[7-b], 1'b1, 1'b0);
            exp_v = sb.pop_front(); total++;
            if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                bad++; $display("FAIL prereset bit %0d got %b want %b", b + 1, {m_a, cnt_a, lk_a, ls_a}, exp_v);
            end
        end
        @(negedge clk);
        val_a = 1'b0;
        #2;
        sb.push_back(ev(0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        exp_v = sb.pop_front(); total++;
        if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
            bad++; $display("FAIL async_reset got %b want %b", {m_a, cnt_a, lk_a, ls_a}, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 6; b < 8; b++) begin
            sb.push_back(ev(0, 0, 0, 0));
            drive_a(PAT[7-b], 1'b1, 1'b0);
            exp_v = sb.pop_front(); total++;
            if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                bad++; $display("FAIL no_history bit %0d got %b want %b", b + 1, {m_a, cnt_a, lk_a, ls_a}, exp_v);
            end
        end
        for (int b = 0; b < 8; b++) begin
            sb.push_back(ev(b == 7, (b == 7) ? 1 : 0, 0, 0));
            drive_a(PAT[7-b], 1'b1, 1'b0);
            exp_v = sb.pop_front(); total++;
            if ({m_a, cnt_a, lk_a, ls_a} !== exp_v) begin
                bad++; $display("FAIL post_reset bit %0d got %b want %b", b + 1, {m_a, cnt_a, lk_a, ls_a}, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        din_a = 1'b0; val_a = 1'b0; clr_a = 1'b0;
        din_b = 1'b0; val_b = 1'b0; clr_b = 1'b0;
        din_c = 1'b0; val_c = 1'b0; clr_c = 1'b0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_single_match();
        test_back_to_back();
        test_lost();
        test_overlap();
        test_saturate_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
